// File: rtl/alu_decode_stage.sv
// Decode stage for the RV32I integer ALU: decodes OP, OP-IMM, LUI and AUIPC and registers
// the ALU controls and operands into a single EXE-stage entry with valid/ready handshaking.
module alu_decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic [31:0] dec_instr,
   input  logic [31:0] dec_pc,
   output logic [4:0]  dec_rs1,
   output logic [4:0]  dec_rs2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   input  logic        flush,
   input  logic        exe_ready,
   output logic        exe_valid_r,
   output logic        exe_illegal_r,
   output logic [3:0]  exe_alu_opc_r,
   output logic        exe_sel_pc_r,
   output logic [31:0] exe_pc_r,
   output logic [31:0] exe_reg1_r,
   output logic [31:0] exe_src2_r,
   output logic [4:0]  exe_rd_r,
   output logic        exe_rd_wen_r
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;

   logic        illegal_d;
   logic [3:0]  opc_d;
   logic        sel_pc_d;
   logic [31:0] reg1_d;
   logic [31:0] src2_d;
   logic        transfer;

   assign opcode  = dec_instr[6:0];
   assign funct3  = dec_instr[14:12];
   assign funct7  = dec_instr[31:25];
   assign rd      = dec_instr[11:7];
   assign imm_i   = {{20{dec_instr[31]}}, dec_instr[31:20]};
   assign imm_u   = {dec_instr[31:12], 12'b0};
   assign shamt   = {27'b0, dec_instr[24:20]};
   assign dec_rs1 = dec_instr[19:15];
   assign dec_rs2 = dec_instr[24:20];

   assign dec_ready = !exe_valid_r || exe_ready;
   // A flush in the same cycle swallows the transfer even though dec_ready stays high.
   assign transfer  = dec_valid && dec_ready && !flush;

   always_comb begin
      illegal_d = 1'b1;
      opc_d     = 4'b0000;
      sel_pc_d  = 1'b0;
      reg1_d    = rf_rdata1;
      src2_d    = 32'b0;
      unique case (opcode)
         OPC_OP: begin
            if (funct7 == F7_ZERO ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               illegal_d = 1'b0;
               opc_d     = {dec_instr[30], funct3};
               src2_d    = rf_rdata2;
            end
         end
         OPC_OP_IMM: begin
            if (funct3 == 3'b001) begin
               if (funct7 == F7_ZERO) begin
                  illegal_d = 1'b0;
                  opc_d     = 4'b0001;
                  src2_d    = shamt;
               end
            end else if (funct3 == 3'b101) begin
               if (funct7 == F7_ZERO || funct7 == F7_ALT) begin
                  illegal_d = 1'b0;
                  opc_d     = {dec_instr[30], 3'b101};
                  src2_d    = shamt;
               end
            end else begin
               illegal_d = 1'b0;
               opc_d     = {1'b0, funct3};
               src2_d    = imm_i;
            end
         end
         OPC_LUI: begin
            illegal_d = 1'b0;
            reg1_d    = 32'b0;
            src2_d    = imm_u;
         end
         OPC_AUIPC: begin
            illegal_d = 1'b0;
            sel_pc_d  = 1'b1;
            src2_d    = imm_u;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exe_valid_r   <= 1'b0;
         exe_illegal_r <= 1'b0;
         exe_alu_opc_r <= 4'b0000;
         exe_sel_pc_r  <= 1'b0;
         exe_pc_r      <= RESET_PC;
         exe_reg1_r    <= 32'b0;
         exe_src2_r    <= 32'b0;
         exe_rd_r      <= 5'b0;
         exe_rd_wen_r  <= 1'b0;
      end else if (transfer) begin
         exe_valid_r   <= 1'b1;
         exe_illegal_r <= illegal_d;
         exe_alu_opc_r <= opc_d;
         exe_sel_pc_r  <= sel_pc_d;
         exe_pc_r      <= dec_pc;
         exe_reg1_r    <= reg1_d;
         exe_src2_r    <= src2_d;
         exe_rd_r      <= rd;
         exe_rd_wen_r  <= !illegal_d && (rd != 5'b0);
      end else if (flush || exe_ready) begin
         exe_valid_r   <= 1'b0;
      end
   end

endmodule
